// File: rtl/fast_pkg.sv
// Shared constants, FSM encoding and threshold helper for the FAST corner controller.
package fast_pkg;

  localparam int FAST_LAT    = 11;
  localparam int FAST_BORDER = 3;
  localparam int W           = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    DRAIN  = 2'd2,
    UPDATE = 2'd3
  } fast_state_e;

  // One adaptation step in W+1 bits so both saturation limits are exact with no wrap.
  function automatic logic [W-1:0] t_adjust(
    input logic [W-1:0] t_cur,
    input logic         up,
    input logic         down,
    input logic [W-1:0] t_min,
    input logic [W-1:0] t_max,
    input int           step
  );
    logic [W:0] sum;
    logic [W:0] dif;
    sum      = {1'b0, t_cur} + (W+1)'(step);
    dif      = {1'b0, t_cur} - (W+1)'(step);
    t_adjust = t_cur;
    if (up) begin
      t_adjust = (sum > {1'b0, t_max}) ? t_max : sum[W-1:0];
    end else if (down) begin
      t_adjust = (dif[W] || (dif < {1'b0, t_min})) ? t_min : dif[W-1:0];
    end
  endfunction

endpackage

// File: rtl/corner_fifo.sv
// Synchronous FIFO with first-word visibility; a write while full is taken when a read happens the same cycle.
module corner_fifo #(
  parameter int DW = 8,
  parameter int D  = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(D);

  logic [DW-1:0] mem [D];
  logic [AW:0]   wp;
  logic [AW:0]   rp;
  logic          do_wr;
  logic          do_rd;

  // Pointers carry one wrap bit so full and empty are distinguishable.
  assign empty = (wp == rp);
  assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);

  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_wr) wp <= wp + 1'b1;
      if (do_rd) rp <= rp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wp[AW-1:0]] <= wr_data;
  end

  assign rd_data = mem[rp[AW-1:0]];

endmodule

// File: rtl/dn.sv
// N-stage delay line of a W-bit word, cleared by reset.
module dn #(
  parameter int W = 1,
  parameter int N = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] sr [N];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) sr[i] <= '0;
    end else begin
      sr[0] <= d;
      for (int i = 1; i < N; i++) sr[i] <= sr[i-1];
    end
  end

  assign q = sr[N-1];

endmodule

// File: rtl/fast_corner_ctrl.sv
// Sequencer around the ast_mask FAST datapath: coordinate tracking, border/budget filtering,
// corner FIFO and per-frame threshold adaptation.
module fast_corner_ctrl
  import fast_pkg::*;
#(
  parameter int           LAT    = FAST_LAT,
  parameter int           IMG_W  = 752,
  parameter int           IMG_H  = 480,
  parameter int           XW     = 11,
  parameter int           YW     = 10,
  parameter int           BORDER = FAST_BORDER,
  parameter int           MAX_C  = 512,
  parameter int           LO_C   = 128,
  parameter logic [W-1:0] T_INIT = 8'h20,
  parameter logic [W-1:0] T_MIN  = 8'h08,
  parameter logic [W-1:0] T_MAX  = 8'hf0,
  parameter int           T_STEP = 4,
  parameter int           FD     = 16
) (
  input  logic          c,
  input  logic          rst,
  input  logic          frame_start,
  input  logic          dv,
  input  logic          q,
  input  logic [W-1:0]  score,
  input  logic          adapt_en,
  input  logic [W-1:0]  t_cfg,
  output logic [W-1:0]  t,
  output logic          cv,
  input  logic          crdy,
  output logic [XW-1:0] cx,
  output logic [YW-1:0] cy,
  output logic [W-1:0]  cs,
  output logic          frame_done,
  output logic [9:0]    frame_cnt,
  output logic [15:0]   drop_cnt,
  output logic          aborted,
  output fast_state_e   state_dbg
);

  localparam int EW  = XW + YW + W;
  localparam int ACW = $clog2(MAX_C + 1);
  localparam int DCW = $clog2(LAT + 1);

  localparam logic [XW-1:0]  X_LO    = XW'(BORDER);
  localparam logic [XW-1:0]  X_HI    = XW'(IMG_W - BORDER);
  localparam logic [YW-1:0]  Y_LO    = YW'(BORDER);
  localparam logic [YW-1:0]  Y_HI    = YW'(IMG_H - BORDER);
  localparam logic [YW-1:0]  Y_LAST  = YW'(IMG_H - 1);
  localparam logic [9:0]     MAX_CV  = 10'(MAX_C);
  localparam logic [9:0]     LO_CV   = 10'(LO_C);
  localparam logic [ACW-1:0] MAX_ACC = ACW'(MAX_C);
  localparam logic [DCW-1:0] DRAIN_N = DCW'(LAT);

  fast_state_e    state;
  fast_state_e    state_n;
  logic [DCW-1:0] drain_cnt;
  logic [DCW-1:0] drain_n;

  logic          dv_q;
  logic          row_end;
  logic [XW-1:0] col;
  logic [YW-1:0] row;

  logic          v_d;
  logic [XW-1:0] x_d;
  logic [YW-1:0] y_d;

  logic           cand_hit;
  logic           accept;
  logic           drop;
  logic [9:0]     cand;
  logic [ACW-1:0] acc_cnt;

  logic          fifo_full;
  logic          fifo_empty;
  logic [EW-1:0] head;
  logic [W-1:0]  t_adapt;

  // ---------------- input-side coordinates ----------------
  assign row_end = dv_q && !dv;

  always_ff @(posedge c) begin
    if (rst || frame_start) begin
      dv_q <= 1'b0;
      col  <= '0;
      row  <= '0;
    end else begin
      dv_q <= dv;
      if (dv) begin
        col <= col + 1'b1;
      end else if (row_end) begin
        col <= '0;
        row <= row + 1'b1;
      end
    end
  end

  // Tail of this line lines up with the ast_mask q/score of the same pixel.
  dn #(
    .W (1 + XW + YW),
    .N (LAT)
  ) u_align (
    .clk (c),
    .rst (rst),
    .d   ({dv, col, row}),
    .q   ({v_d, x_d, y_d})
  );

  // ---------------- candidate filtering and budget ----------------
  assign cand_hit = v_d && q &&
                    (x_d >= X_LO) && (x_d < X_HI) &&
                    (y_d >= Y_LO) && (y_d < Y_HI);
  assign accept   = cand_hit && (acc_cnt < MAX_ACC) && !fifo_full;
  assign drop     = cand_hit && !accept;

  always_ff @(posedge c) begin
    if (rst || frame_start) begin
      cand     <= '0;
      acc_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      if (cand_hit && (cand != 10'h3ff))      cand     <= cand + 1'b1;
      if (accept)                             acc_cnt  <= acc_cnt + 1'b1;
      if (drop && (drop_cnt != 16'hffff))     drop_cnt <= drop_cnt + 1'b1;
    end
  end

  // ---------------- corner stream ----------------
  // Stream handshake: cx/cy/cs are meaningful while cv is high and stay stable until the
  // cycle where cv && crdy, at which point the head entry is consumed.
  corner_fifo #(
    .DW (EW),
    .D  (FD)
  ) u_fifo (
    .clk     (c),
    .rst     (rst),
    .wr_en   (accept),
    .wr_data ({x_d, y_d, score}),
    .rd_en   (cv && crdy),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign cv = !fifo_empty;
  assign cx = cv ? head[EW-1 -: XW]   : '0;
  assign cy = cv ? head[W +: YW]      : '0;
  assign cs = cv ? head[W-1:0]        : '0;

  // ---------------- frame sequencer ----------------
  always_ff @(posedge c) begin
    if (rst) begin
      state     <= IDLE;
      drain_cnt <= '0;
    end else begin
      state     <= state_n;
      drain_cnt <= drain_n;
    end
  end

  always_comb begin
    state_n    = state;
    drain_n    = drain_cnt;
    frame_done = 1'b0;
    aborted    = 1'b0;
    case (state)
      IDLE: begin
        if (frame_start) state_n = RUN;
      end
      RUN: begin
        if (frame_start) begin
          aborted = 1'b1;
        end else if (row_end && (row == Y_LAST)) begin
          state_n = DRAIN;
          drain_n = DRAIN_N;
        end
      end
      DRAIN: begin
        // Leaves after LAT cycles so the last row's results are counted before UPDATE.
        if (frame_start) begin
          aborted = 1'b1;
          state_n = RUN;
        end else begin
          drain_n = drain_cnt - 1'b1;
          if (drain_cnt == DCW'(1)) state_n = UPDATE;
        end
      end
      UPDATE: begin
        frame_done = 1'b1;
        state_n    = frame_start ? RUN : IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign state_dbg = state;

  // ---------------- threshold and frame statistics ----------------
  assign t_adapt = t_adjust(t, (cand > MAX_CV), (cand < LO_CV), T_MIN, T_MAX, T_STEP);

  always_ff @(posedge c) begin
    if (rst) begin
      t         <= T_INIT;
      frame_cnt <= '0;
    end else begin
      if (state == UPDATE) begin
        frame_cnt <= cand;
        t         <= adapt_en ? t_adapt : t_cfg;
      end else if ((state == IDLE) && frame_start && !adapt_en) begin
        t <= t_cfg;
      end
    end
  end

endmodule
